// File: rtl/stg1if_pkg.sv
// Shared sizes, state encodings and constants for the instruction fetch stage.
package stg1if_pkg;

    // Word address and instruction widths used across the fetch slice.
    localparam int SIZE_ADDR = 8;
    localparam int SIZE_DATA = 32;
    localparam int HBIT_ADDR = SIZE_ADDR - 1;
    localparam int HBIT_DATA = SIZE_DATA - 1;

    // Instruction presented to ID when there is nothing real to hand over.
    localparam logic [HBIT_DATA:0] INSTR_NOP = '0;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } if_state_e;

    // Next sequential word address; the all-ones address wraps to zero.
    function automatic logic [HBIT_ADDR:0] pc_next(input logic [HBIT_ADDR:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/stg1if_skid.sv
// One-entry pc/instr holding register used to park a response while ID stalls.
module stg1if_skid
    import stg1if_pkg::*;
(
    input  logic             iw_clk,
    input  logic             iw_rst_n,
    input  logic             iw_load,
    input  logic             iw_clear,
    input  logic [HBIT_ADDR:0] iw_pc,
    input  logic [HBIT_DATA:0] iw_instr,
    output logic [HBIT_ADDR:0] ow_pc,
    output logic [HBIT_DATA:0] ow_instr,
    output logic             ow_full
);

    logic               full_p0;
    logic [HBIT_ADDR:0] pc_p0;
    logic [HBIT_DATA:0] instr_p0;

    // Occupancy flag: load marks the entry full, clear (drain or redirect) empties it.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            full_p0 <= 1'b0;
        end else if (iw_load) begin
            full_p0 <= 1'b1;
        end else if (iw_clear) begin
            full_p0 <= 1'b0;
        end
    end

    // Payload is only meaningful while full, so it carries no reset.
    always_ff @(posedge iw_clk) begin
        if (iw_load) begin
            pc_p0    <= iw_pc;
            instr_p0 <= iw_instr;
        end
    end

    assign ow_pc    = pc_p0;
    assign ow_instr = instr_p0;
    assign ow_full  = full_p0;

endmodule

// File: rtl/stg1if.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake with
// one outstanding request, and presents pc/instr/valid to the IF->ID register.
module stg1if
    import stg1if_pkg::*;
#(
    parameter logic [HBIT_ADDR:0] RESET_PC = '0
) (
    input  logic               iw_clk,
    input  logic               iw_rst_n,
    input  logic               iw_stall,
    input  logic               iw_branch_valid,
    input  logic [HBIT_ADDR:0] iw_branch_pc,
    output logic               ow_imem_req,
    output logic [HBIT_ADDR:0] ow_imem_addr,
    input  logic               iw_imem_ack,
    input  logic [HBIT_DATA:0] iw_imem_rdata,
    output logic [HBIT_ADDR:0] ow_pc,
    output logic [HBIT_DATA:0] ow_instr,
    output logic               ow_valid
);

    if_state_e          state;
    logic [HBIT_ADDR:0] pc_p0;
    logic [HBIT_ADDR:0] tgt_p0;
    logic               req_p0;
    logic [HBIT_ADDR:0] addr_p0;
    logic [HBIT_ADDR:0] pc_p1;
    logic [HBIT_DATA:0] instr_p1;
    logic               vld_p1;

    logic               ack;
    logic               skid_load;
    logic               skid_clear;
    logic [HBIT_ADDR:0] skid_pc;
    logic [HBIT_DATA:0] skid_instr;
    logic               skid_full;

    // An ack is only meaningful against a request we are actually driving.
    assign ack = iw_imem_ack & req_p0;

    // Park the response when ID is stalled on a valid instruction.
    assign skid_load  = (state == ST_FETCH) && ack && !iw_branch_valid
                        && iw_stall && vld_p1;
    // Drained on the first non-stall cycle of HOLD, dropped on any redirect.
    assign skid_clear = ((state == ST_HOLD) && !iw_stall)
                        || ((state != ST_BOOT) && iw_branch_valid);

    stg1if_skid u_skid (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .iw_load  (skid_load),
        .iw_clear (skid_clear),
        .iw_pc    (pc_p0),
        .iw_instr (iw_imem_rdata),
        .ow_pc    (skid_pc),
        .ow_instr (skid_instr),
        .ow_full  (skid_full)
    );

    // Fetch sequencer with registered request and IF->ID outputs.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state    <= ST_BOOT;
            pc_p0    <= RESET_PC;
            tgt_p0   <= RESET_PC;
            req_p0   <= 1'b0;
            addr_p0  <= RESET_PC;
            pc_p1    <= '0;
            instr_p1 <= INSTR_NOP;
            vld_p1   <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    // A redirect during boot simply replaces the start address.
                    if (iw_branch_valid) begin
                        pc_p0   <= iw_branch_pc;
                        addr_p0 <= iw_branch_pc;
                    end else begin
                        addr_p0 <= pc_p0;
                    end
                    req_p0 <= 1'b1;
                    state  <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (iw_branch_valid) begin
                        vld_p1   <= 1'b0;
                        instr_p1 <= INSTR_NOP;
                        if (ack) begin
                            // Response for the old path is dropped; restart at target.
                            pc_p0   <= iw_branch_pc;
                            addr_p0 <= iw_branch_pc;
                            req_p0  <= 1'b1;
                        end else begin
                            // Request in flight must complete before we can redirect.
                            tgt_p0 <= iw_branch_pc;
                            state  <= ST_FLUSH;
                        end
                    end else if (ack) begin
                        pc_p0   <= pc_next(pc_p0);
                        addr_p0 <= pc_next(pc_p0);
                        if (!iw_stall || !vld_p1) begin
                            pc_p1    <= pc_p0;
                            instr_p1 <= iw_imem_rdata;
                            vld_p1   <= 1'b1;
                            req_p0   <= 1'b1;
                        end else begin
                            // Response went to the skid; stop fetching until it drains.
                            req_p0 <= 1'b0;
                            state  <= ST_HOLD;
                        end
                    end else if (!iw_stall) begin
                        vld_p1   <= 1'b0;
                        instr_p1 <= INSTR_NOP;
                    end
                end

                ST_HOLD: begin
                    if (iw_branch_valid) begin
                        vld_p1   <= 1'b0;
                        instr_p1 <= INSTR_NOP;
                        pc_p0    <= iw_branch_pc;
                        addr_p0  <= iw_branch_pc;
                        req_p0   <= 1'b1;
                        state    <= ST_FETCH;
                    end else if (!iw_stall && skid_full) begin
                        pc_p1    <= skid_pc;
                        instr_p1 <= skid_instr;
                        vld_p1   <= 1'b1;
                        addr_p0  <= pc_p0;
                        req_p0   <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end

                ST_FLUSH: begin
                    // Request and address stay on the old word until its ack.
                    if (iw_branch_valid) begin
                        vld_p1   <= 1'b0;
                        instr_p1 <= INSTR_NOP;
                        if (ack) begin
                            pc_p0   <= iw_branch_pc;
                            addr_p0 <= iw_branch_pc;
                            state   <= ST_FETCH;
                        end else begin
                            tgt_p0 <= iw_branch_pc;
                        end
                    end else if (ack) begin
                        pc_p0   <= tgt_p0;
                        addr_p0 <= tgt_p0;
                        state   <= ST_FETCH;
                    end else if (!iw_stall) begin
                        vld_p1   <= 1'b0;
                        instr_p1 <= INSTR_NOP;
                    end
                end

                default: begin
                    state  <= ST_BOOT;
                    req_p0 <= 1'b0;
                end
            endcase
        end
    end

    assign ow_imem_req  = req_p0;
    assign ow_imem_addr = addr_p0;
    assign ow_pc        = pc_p1;
    assign ow_instr     = instr_p1;
    assign ow_valid     = vld_p1;

endmodule

// File: tb/tb_stg1if.sv
// Randomized bench for stg1if against a queue-based model of the fetch rules.
module tb_stg1if;
    import stg1if_pkg::*;

    localparam logic [HBIT_ADDR:0] RST_PC = 8'h10;

    logic               clk;
    logic               rst_n;
    logic               stall;
    logic               br_v;
    logic [HBIT_ADDR:0] br_pc;
    logic               ack;
    logic [HBIT_DATA:0] rdata;
    logic               imem_req;
    logic [HBIT_ADDR:0] imem_addr;
    logic [HBIT_ADDR:0] o_pc;
    logic [HBIT_DATA:0] o_instr;
    logic               o_valid;

    stg1if #(.RESET_PC(RST_PC)) dut (
        .iw_clk          (clk),
        .iw_rst_n        (rst_n),
        .iw_stall        (stall),
        .iw_branch_valid (br_v),
        .iw_branch_pc    (br_pc),
        .ow_imem_req     (imem_req),
        .ow_imem_addr    (imem_addr),
        .iw_imem_ack     (ack),
        .iw_imem_rdata   (rdata),
        .ow_pc           (o_pc),
        .ow_instr        (o_instr),
        .ow_valid        (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [HBIT_ADDR:0] pc;
        logic [HBIT_DATA:0] instr;
    } fetched_t;

    // Reference model: fetched-but-unpresented words, current output, fetch pointer.
    fetched_t           pend[$];
    bit                 m_boot;
    bit                 m_disc;
    bit                 m_req;
    bit                 m_vld;
    logic [HBIT_ADDR:0] m_pc;
    logic [HBIT_ADDR:0] m_tgt;
    logic [HBIT_ADDR:0] m_addr;
    logic [HBIT_ADDR:0] m_opc;
    logic [HBIT_DATA:0] m_oinstr;
    int                 wcnt;
    int                 n_cmp = 0;
    int                 n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_boot   = 1'b1;
        m_disc   = 1'b0;
        m_req    = 1'b0;
        m_vld    = 1'b0;
        m_pc     = RST_PC;
        m_tgt    = RST_PC;
        m_addr   = RST_PC;
        m_opc    = '0;
        m_oinstr = '0;
        wcnt     = 0;
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step(input bit s, input bit b, input logic [HBIT_ADDR:0] bpc,
                              input bit a, input logic [HBIT_DATA:0] d);
        fetched_t it;
        if (m_boot) begin
            m_boot = 1'b0;
            if (b) m_pc = bpc;
            m_req  = 1'b1;
            m_addr = m_pc;
            return;
        end
        if (b) begin
            m_vld    = 1'b0;
            m_oinstr = '0;
            pend.delete();
            if (m_req && !a) begin
                m_disc = 1'b1;
                m_tgt  = bpc;
            end else begin
                m_disc = 1'b0;
                m_pc   = bpc;
            end
        end else begin
            if (a) begin
                if (m_disc) begin
                    m_disc = 1'b0;
                    m_pc   = m_tgt;
                end else begin
                    it.pc    = m_pc;
                    it.instr = d;
                    pend.push_back(it);
                    m_pc = m_pc + 1'b1;
                end
            end
            if ((!s || !m_vld) && pend.size() > 0) begin
                it       = pend.pop_front();
                m_opc    = it.pc;
                m_oinstr = it.instr;
                m_vld    = 1'b1;
            end else if (!s) begin
                m_vld    = 1'b0;
                m_oinstr = '0;
            end
        end
        // One outstanding request; no new fetch while a word is parked.
        m_req = (pend.size() == 0);
        if (!m_disc) m_addr = m_pc;
    endtask

    task automatic check_outputs();
        chk("valid", 64'(o_valid), 64'(m_vld));
        chk("pc", 64'(o_pc), 64'(m_opc));
        chk("instr", 64'(o_instr), 64'(m_oinstr));
        chk("req", 64'(imem_req), 64'(m_req));
        if (m_req) chk("addr", 64'(imem_addr), 64'(m_addr));
    endtask

    // Drive one cycle of random stimulus, step the model, then sample after the edge.
    task automatic cycle(input int maxw, input int p_stall, input int p_br);
        int sel;
        stall = ($urandom_range(99, 0) < p_stall);
        br_v  = ($urandom_range(99, 0) < p_br);
        sel   = $urandom_range(3, 0);
        if (sel == 0)      br_pc = '1;
        else if (sel == 1) br_pc = 8'hFD;
        else               br_pc = 8'($urandom);
        ack   = m_req && (wcnt == 0);
        rdata = $urandom;
        if (m_req) begin
            if (wcnt == 0) wcnt = $urandom_range(maxw, 0);
            else           wcnt = wcnt - 1;
        end
        model_step(stall, br_v, br_pc, ack, rdata);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input int maxw, input int p_stall, input int p_br);
        for (int i = 0; i < n; i++) cycle(maxw, p_stall, p_br);
    endtask

    task automatic async_reset_check();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_pc", 64'(o_pc), 64'(0));
        chk("rst_instr", 64'(o_instr), 64'(0));
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_addr", 64'(imem_addr), 64'(RST_PC));
        stall = 1'b0;
        br_v  = 1'b0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        br_v  = 1'b0;
        br_pc = '0;
        ack   = 1'b0;
        rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Zero-wait memory, no stalls or redirects: one instruction per cycle.
        run(30, 0, 0, 0);
        // Zero-wait with stalls: exercises the skid and HOLD release.
        run(300, 0, 40, 0);
        // Wait states, stalls and redirects together.
        run(600, 3, 30, 10);
        // Dense redirects, so branches land in waits and on acks.
        run(300, 2, 20, 35);

        // Reach a pending discard, then reset asynchronously in the middle of it.
        for (int i = 0; i < 200 && !m_disc; i++) cycle(3, 20, 30);
        async_reset_check();
        run(20, 0, 0, 0);

        // Reset again while a word is parked in the skid.
        for (int i = 0; i < 200 && pend.size() == 0; i++) cycle(0, 60, 0);
        async_reset_check();
        run(400, 3, 25, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
